// File: rtl/icache_miss_handler_if.sv
// icache_miss_handler_if
//   Groups the L1I miss request, next-level memory read and refill signals
//   of the instruction cache miss handler.
//   slave  : the miss handler's view (miss/memory inputs, request/refill outputs)
//   master : the surrounding L1I/memory view (the reverse directions)
interface icache_miss_handler_if #(
    parameter int fetchingAddressWidth    = 64,
    parameter int cacheLineWith           = 512,
    parameter int memBeatWidth            = 64,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64
);
    // L1I miss request
    logic                               cacheMiss_i;
    logic [fetchingAddressWidth-1:0]    missedAddress_i;
    logic [instructionCounterWidth-1:0] missedInstMajorId_i;
    logic [PidSize-1:0]                 missedPid_i;
    logic [TidSize-1:0]                 missedTid_i;
    // next-level read
    logic                               memReadReq_o;
    logic [fetchingAddressWidth-1:0]    memReadAddress_o;
    logic                               memReadAck_i;
    logic                               memDataValid_i;
    logic [memBeatWidth-1:0]            memData_i;
    // refill to L1I
    logic                               cacheUpdate_o;
    logic [fetchingAddressWidth-1:0]    cacheUpdateAddress_o;
    logic [PidSize-1:0]                 cacheUpdatePid_o;
    logic [TidSize-1:0]                 cacheUpdateTid_o;
    logic [instructionCounterWidth-1:0] missedInstMajorId_o;
    logic [cacheLineWith-1:0]           cacheUpdateLine_o;
    // status
    logic                               busy_o;
    logic                               missOverflow_o;

    modport slave (
        input  cacheMiss_i, missedAddress_i, missedInstMajorId_i, missedPid_i, missedTid_i,
               memReadAck_i, memDataValid_i, memData_i,
        output memReadReq_o, memReadAddress_o, cacheUpdate_o, cacheUpdateAddress_o,
               cacheUpdatePid_o, cacheUpdateTid_o, missedInstMajorId_o, cacheUpdateLine_o,
               busy_o, missOverflow_o
    );

    modport master (
        output cacheMiss_i, missedAddress_i, missedInstMajorId_i, missedPid_i, missedTid_i,
               memReadAck_i, memDataValid_i, memData_i,
        input  memReadReq_o, memReadAddress_o, cacheUpdate_o, cacheUpdateAddress_o,
               cacheUpdatePid_o, cacheUpdateTid_o, missedInstMajorId_o, cacheUpdateLine_o,
               busy_o, missOverflow_o
    );
endinterface

// File: rtl/icache_miss_handler.sv
// icache_miss_handler
//   Queues up to two L1I misses (line address, major ID, Pid, Tid), fetches
//   each line from the next level as cacheLineWith/memBeatWidth beats and
//   returns it to the L1I with a one-cycle cacheUpdate_o strobe.
//   Ports:
//     clock_i : clock, rising edge
//     reset_i : synchronous active-low reset
//     bus     : icache_miss_handler_if.slave (miss request, memory read,
//               refill, busy and overflow signals)
module icache_miss_handler #(
    parameter int fetchingAddressWidth    = 64,
    parameter int cacheLineWith           = 512,
    parameter int offsetWidth             = 6,
    parameter int memBeatWidth            = 64,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    icache_miss_handler_if.slave  bus
);
    localparam int beatCount = cacheLineWith / memBeatWidth;
    localparam int beatCntW  = (beatCount > 1) ? $clog2(beatCount) : 1;
    localparam logic [beatCntW-1:0] lastBeat = beatCntW'(beatCount - 1);
    localparam logic [fetchingAddressWidth-1:0] lineMask =
        {{(fetchingAddressWidth-offsetWidth){1'b1}}, {offsetWidth{1'b0}}};

    typedef enum logic [1:0] {IDLE, REQ, BEAT, UPDATE} stateE;
    stateE state, nextState;

    // miss queue: two entries, per-entry valid bits, 1-bit wrapping pointers
    logic [1:0]                         qValid;
    logic                               rdPtr, wrPtr;
    logic [fetchingAddressWidth-1:0]    qAddr  [2];
    logic [instructionCounterWidth-1:0] qMajId [2];
    logic [PidSize-1:0]                 qPid   [2];
    logic [TidSize-1:0]                 qTid   [2];

    logic [fetchingAddressWidth-1:0] missLine;
    logic dup, full, empty, pop, push, drop;

    // line buffer: beat 0 lands in the most significant slot
    logic [beatCount-1:0][memBeatWidth-1:0] lineBuf;
    logic [beatCntW-1:0] beatCnt;
    logic beatWr, reqNext, updNext;

    logic                               memReadReqQ, cacheUpdateQ, missOverflowQ;
    logic [fetchingAddressWidth-1:0]    memReadAddressQ, updAddrQ;
    logic [PidSize-1:0]                 updPidQ;
    logic [TidSize-1:0]                 updTidQ;
    logic [instructionCounterWidth-1:0] updMajIdQ;

    assign missLine = bus.missedAddress_i & lineMask;
    assign full     = &qValid;
    assign empty    = ~|qValid;
    // head leaves the queue only once its refill strobe has been issued
    assign pop      = (state == UPDATE);

    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < 2; i++)
            if (qValid[i] && qAddr[i] == missLine && qPid[i] == bus.missedPid_i)
                dup = 1'b1;
    end

    // a full queue still takes a miss when the head pops on the same edge
    assign push = bus.cacheMiss_i && !dup && (!full || pop);
    assign drop = bus.cacheMiss_i && !dup && full && !pop;

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            qValid <= 2'b00;
            rdPtr  <= 1'b0;
            wrPtr  <= 1'b0;
        end else begin
            if (pop) begin
                qValid[rdPtr] <= 1'b0;
                rdPtr         <= ~rdPtr;
            end
            // ordered after pop: when full, wrPtr == rdPtr and the new entry wins
            if (push) begin
                qValid[wrPtr] <= 1'b1;
                wrPtr         <= ~wrPtr;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (push) begin
            qAddr[wrPtr]  <= missLine;
            qMajId[wrPtr] <= bus.missedInstMajorId_i;
            qPid[wrPtr]   <= bus.missedPid_i;
            qTid[wrPtr]   <= bus.missedTid_i;
        end
    end

    // FSM state register
    always_ff @(posedge clock_i) begin
        if (!reset_i) state <= IDLE;
        else          state <= nextState;
    end

    // FSM next state
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (!empty) nextState = REQ;
            REQ:     if (bus.memReadAck_i) nextState = BEAT;
            BEAT:    if (bus.memDataValid_i && beatCnt == lastBeat) nextState = UPDATE;
            UPDATE:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // FSM outputs, decoded from the next state so the registered copies
    // line up with the state they belong to
    always_comb begin
        reqNext = (nextState == REQ);
        updNext = (nextState == UPDATE);
        beatWr  = (state == BEAT) && bus.memDataValid_i;
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            memReadReqQ     <= 1'b0;
            memReadAddressQ <= '0;
            cacheUpdateQ    <= 1'b0;
            missOverflowQ   <= 1'b0;
            updAddrQ        <= '0;
            updPidQ         <= '0;
            updTidQ         <= '0;
            updMajIdQ       <= '0;
            lineBuf         <= '0;
            beatCnt         <= '0;
        end else begin
            memReadReqQ     <= reqNext;
            memReadAddressQ <= reqNext ? qAddr[rdPtr] : '0;
            cacheUpdateQ    <= updNext;
            missOverflowQ   <= drop;
            if (updNext) begin
                updAddrQ  <= qAddr[rdPtr];
                updPidQ   <= qPid[rdPtr];
                updTidQ   <= qTid[rdPtr];
                updMajIdQ <= qMajId[rdPtr];
            end
            if (state == REQ && bus.memReadAck_i) beatCnt <= '0;
            else if (beatWr)                      beatCnt <= beatCnt + 1'b1;
            if (beatWr) lineBuf[lastBeat - beatCnt] <= bus.memData_i;
        end
    end

    assign bus.memReadReq_o         = memReadReqQ;
    assign bus.memReadAddress_o     = memReadAddressQ;
    assign bus.cacheUpdate_o        = cacheUpdateQ;
    assign bus.cacheUpdateAddress_o = updAddrQ;
    assign bus.cacheUpdatePid_o     = updPidQ;
    assign bus.cacheUpdateTid_o     = updTidQ;
    assign bus.missedInstMajorId_o  = updMajIdQ;
    assign bus.cacheUpdateLine_o    = lineBuf;
    assign bus.missOverflow_o       = missOverflowQ;
    assign bus.busy_o               = (state != IDLE) || !empty;
endmodule
